// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared state encoding and defaults for the IMEM boot loader
package imem_boot_loader_pkg;

   localparam int IMEM_WORDS_DEFAULT = 64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_DRAIN  = 3'd2,
      ST_SRESET = 3'd3,
      ST_RUN    = 3'd4
   } boot_state_e;

endpackage

// File: rtl/imem_boot_loader_boot_addr_counter.sv
// rtl/imem_boot_loader_boot_addr_counter.sv - IMEM word address and loaded-word counter
module boot_addr_counter
   import imem_boot_loader_pkg::*;
#(
   parameter int IMEM_WORDS = IMEM_WORDS_DEFAULT,
   parameter int AW         = 6,
   parameter int CNT_W      = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [AW-1:0]    addr,
   output logic [CNT_W-1:0] word_count,
   output logic             full
);

   logic [AW-1:0]    addr_q, addr_d;
   logic [CNT_W-1:0] word_count_q, word_count_d;

   assign full       = (addr_q == AW'(IMEM_WORDS - 1));
   assign addr       = addr_q;
   assign word_count = word_count_q;

   // addr saturates on the last slot so it never wraps; word_count still reaches IMEM_WORDS
   always_comb begin
      addr_d       = addr_q;
      word_count_d = word_count_q;
      if (clr) begin
         addr_d       = '0;
         word_count_d = '0;
      end else if (inc) begin
         addr_d       = full ? addr_q : addr_q + AW'(1);
         word_count_d = word_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q       <= '0;
         word_count_q <= '0;
      end else begin
         addr_q       <= addr_d;
         word_count_q <= word_count_d;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a program into CPU IMEM, pulses softReset, then enables power
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int IMEM_WORDS    = IMEM_WORDS_DEFAULT,
   parameter int SRESET_CYCLES = 1,
   parameter int CNT_W         = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic             writeI,
   output logic [31:0]      dataI,
   output logic [31:0]      TPC,
   output logic             softReset,
   output logic             power,
   output logic             busy,
   output logic [CNT_W-1:0] word_count,
   output logic             overflow
);

   localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
   localparam int SW = (SRESET_CYCLES > 1) ? $clog2(SRESET_CYCLES) : 1;

   boot_state_e   state_q, state_d;
   logic [SW-1:0] srst_cnt_q, srst_cnt_d;
   logic          write_i_q, write_i_d;
   logic [31:0]   data_i_q, data_i_d;
   logic [31:0]   tpc_q, tpc_d;
   logic          soft_reset_q, soft_reset_d;
   logic          power_q, power_d;
   logic          busy_q, busy_d;
   logic          overflow_q, overflow_d;

   logic          accept;
   logic          cnt_clr;
   logic          addr_full;
   logic [AW-1:0] addr;

   assign in_ready = (state_q == ST_LOAD);
   assign accept   = in_ready && in_valid;
   assign cnt_clr  = start && ((state_q == ST_IDLE) || (state_q == ST_RUN));

   boot_addr_counter #(
      .IMEM_WORDS (IMEM_WORDS),
      .AW         (AW),
      .CNT_W      (CNT_W)
   ) u_addr_cnt (
      .clk        (clk),
      .reset      (reset),
      .clr        (cnt_clr),
      .inc        (accept),
      .addr       (addr),
      .word_count (word_count),
      .full       (addr_full)
   );

   always_comb begin
      state_d    = state_q;
      srst_cnt_d = '0;
      write_i_d  = 1'b0;
      data_i_d   = data_i_q;
      tpc_d      = tpc_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_LOAD;
               overflow_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               write_i_d = 1'b1;
               data_i_d  = in_data;
               tpc_d     = 32'(addr) << 2;
               if (in_last) begin
                  state_d = ST_DRAIN;
               end else if (addr_full) begin
                  state_d    = ST_DRAIN;
                  overflow_d = 1'b1;
               end
            end
         end
         ST_DRAIN: state_d = ST_SRESET;
         ST_SRESET: begin
            if (srst_cnt_q == SW'(SRESET_CYCLES - 1)) state_d = ST_RUN;
            else srst_cnt_d = srst_cnt_q + SW'(1);
         end
         ST_RUN: begin
            if (start) begin
               state_d    = ST_LOAD;
               overflow_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Status outputs follow the state being entered so they line up with state_q next cycle
      soft_reset_d = (state_d == ST_SRESET);
      power_d      = (state_d == ST_RUN);
      busy_d       = (state_d == ST_LOAD) || (state_d == ST_DRAIN) || (state_d == ST_SRESET);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         srst_cnt_q   <= '0;
         write_i_q    <= 1'b0;
         data_i_q     <= '0;
         tpc_q        <= '0;
         soft_reset_q <= 1'b0;
         power_q      <= 1'b0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         srst_cnt_q   <= srst_cnt_d;
         write_i_q    <= write_i_d;
         data_i_q     <= data_i_d;
         tpc_q        <= tpc_d;
         soft_reset_q <= soft_reset_d;
         power_q      <= power_d;
         busy_q       <= busy_d;
         overflow_q   <= overflow_d;
      end
   end

   assign writeI    = write_i_q;
   assign dataI     = data_i_q;
   assign TPC       = tpc_q;
   assign softReset = soft_reset_q;
   assign power     = power_q;
   assign busy      = busy_q;
   assign overflow  = overflow_q;

endmodule
